// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-shaping blocks: FSM state encodings and default counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pulse_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter that stops at zero instead of wrapping; zero flag decoded from the register.
// Latency: load/decrement visible one cycle after the request.
// Backpressure: none; load has priority over decrement.
module load_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: a load wins, otherwise step down while enabled and not already at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle strobes into an output level W cycles wide, followed by at least G low cycles.
// Latency: o_level rises one cycle after an accepted strobe from IDLE.
// Backpressure: none; one strobe is queued while busy, any further strobe is discarded and flagged on o_drop.
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             i_pulse,
    input  logic [CNT_W-1:0] i_width,
    input  logic [CNT_W-1:0] i_gap,
    input  logic             i_retrig,
    output logic             o_level,
    output logic             o_busy,
    output logic             o_drop
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic             level_q, level_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    // Counter reload values: a programmed width/gap of 0 behaves as 1, so W-1/G-1 bottom out at 0.
    logic [CNT_W-1:0] w_m1;
    logic [CNT_W-1:0] g_m1;
    assign w_m1 = (i_width == '0) ? '0 : (i_width - ONE);
    assign g_m1 = (i_gap   == '0) ? '0 : (i_gap   - ONE);

    load_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (Clock),
        .rst_n    (Resetn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (1'b1),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Next-state, queue and drop decisions; counter loads happen only on phase entry or retrigger.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        drop_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = w_m1;
        case (state_q)
            S_IDLE: begin
                if (i_pulse) begin
                    state_d      = S_HIGH;
                    cnt_load     = 1'b1;
                    cnt_load_val = w_m1;
                end
            end
            S_HIGH: begin
                if (i_pulse && i_retrig) begin
                    // Restart the high time, including in its last cycle, so the level never dips.
                    cnt_load     = 1'b1;
                    cnt_load_val = w_m1;
                end else begin
                    if (i_pulse) begin
                        if (pending_q) begin
                            drop_d = 1'b1;
                        end else begin
                            pending_d = 1'b1;
                        end
                    end
                    if (cnt_zero) begin
                        state_d      = S_GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = g_m1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    if (pending_q || i_pulse) begin
                        state_d      = S_HIGH;
                        cnt_load     = 1'b1;
                        cnt_load_val = w_m1;
                        pending_d    = 1'b0;
                        // Queued strobe is consumed now; a fresh one in the same cycle has nowhere to go.
                        drop_d       = pending_q && i_pulse;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (i_pulse) begin
                    if (pending_q) begin
                        drop_d = 1'b1;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = 1'b0;
            end
        endcase
        level_d = (state_d == S_HIGH);
        busy_d  = (state_d != S_IDLE) || pending_d;
    end

    // State and registered outputs; reset discards any queued strobe and cuts an active pulse short.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            level_q   <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            level_q   <= level_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign o_level = level_q;
    assign o_busy  = busy_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scenarios for pulse_stretcher; per-cycle expected outputs queued by stimulus, checked by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pulse;
    logic [7:0] width;
    logic [7:0] gap;
    logic       retrig;
    logic       level;
    logic       busy;
    logic       drop;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .CNT_W (8)
    ) dut (
        .Clock    (clk),
        .Resetn   (resetn),
        .i_pulse  (pulse),
        .i_width  (width),
        .i_gap    (gap),
        .i_retrig (retrig),
        .o_level  (level),
        .o_busy   (busy),
        .o_drop   (drop)
    );

    typedef struct {
        int   scen;
        int   cyc;
        logic lvl;
        logic bsy;
        logic drp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Monitor: one expected output triple per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            total++;
            if ({level, busy, drop} !== {mon_e.lvl, mon_e.bsy, mon_e.drp}) begin
                bad++;
                $display("FAIL s%0d_c%0d: got level/busy/drop=%b%b%b expected %b%b%b",
                         mon_e.scen, mon_e.cyc, level, busy, drop, mon_e.lvl, mon_e.bsy, mon_e.drp);
            end
        end
    end

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] b1(input int n);
        logic [63:0] m;
        m = '0;
        m[n] = 1'b1;
        return m;
    endfunction

    // Cycle 0 is the first cycle after a two-cycle reset; masks give per-cycle stimulus and expectations.
    task automatic scen(input int id, input int w, input int g, input logic rt,
                        input logic [63:0] stb, input logic [63:0] rstm,
                        input logic [63:0] lvlm, input logic [63:0] bsym,
                        input logic [63:0] drpm, input int n);
        width  = w[7:0];
        gap    = g[7:0];
        retrig = rt;
        pulse  = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            pulse  = stb[c];
            resetn = ~rstm[c];
            sb.push_back('{id, c, lvlm[c], bsym[c], drpm[c]});
        end
        @(posedge clk);
        #1;
        pulse  = 1'b0;
        resetn = 1'b1;
        for (int k = 0; k < 4 && sb.size() != 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL s%0d_drain: got %0d unchecked entries expected 0", id, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        resetn = 1'b0;
        pulse  = 1'b0;
        width  = 8'd1;
        gap    = 8'd1;
        retrig = 1'b0;

        // W=3 G=2, single strobe.
        scen(1, 3, 2, 1'b0, b1(10), '0, rng(11, 13), rng(11, 15), '0, 20);
        // W=0 G=0 act as 1; second strobe in the only HIGH cycle is queued behind a 1-cycle gap.
        scen(2, 0, 0, 1'b0, b1(5) | b1(6), '0, b1(6) | b1(8), rng(6, 9), '0, 14);
        // W=4 G=2, queue one strobe, drop the next.
        scen(3, 4, 2, 1'b0, b1(10) | b1(12) | b1(13), '0,
             rng(11, 14) | rng(17, 20), rng(11, 22), b1(14), 28);
        // Retrigger mid-pulse extends it; nothing pending afterwards.
        scen(4, 4, 2, 1'b1, b1(10) | b1(13), '0, rng(11, 17), rng(11, 19), '0, 24);
        // Retrigger in the final HIGH cycle, no low glitch.
        scen(5, 2, 0, 1'b1, b1(5) | b1(7), '0, rng(6, 9), rng(6, 10), '0, 16);
        // Strobe in the final GAP cycle goes straight back to HIGH.
        scen(6, 2, 3, 1'b0, b1(5) | b1(10), '0, rng(6, 7) | rng(11, 12), rng(6, 15), '0, 20);
        // Strobe earlier in GAP is queued; a second one there is dropped.
        scen(7, 2, 3, 1'b0, b1(5) | b1(8) | b1(9), '0,
             rng(6, 7) | rng(11, 12), rng(6, 15), b1(10), 20);
        // Reset in the 2nd HIGH cycle with a strobe pending and a coincident strobe.
        scen(8, 4, 2, 1'b0, b1(5) | b1(6) | b1(7), b1(7), rng(6, 7), rng(6, 7), '0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
